// File: rtl/frame_buf_multi.sv
// Ring of NUM_BUFS frame buffers. The writer fills one buffer at a time and commits it when full.
// The reader drains committed buffers in order and releases each one after its last word is read.
module frame_buf_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 16,
  parameter int NUM_BUFS   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          wr_rdy,
  input  logic                          rd_en_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          rd_data_valid,
  output logic                          frame_wr_done,
  output logic                          frame_rd_done,
  output logic [$clog2(NUM_BUFS+1)-1:0] bufs_full,
  output logic [$clog2(NUM_BUFS)-1:0]   wr_buf_idx,
  output logic [$clog2(NUM_BUFS)-1:0]   rd_buf_idx,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int AW    = $clog2(BUF_SIZE);
  localparam int BW    = $clog2(NUM_BUFS);
  localparam int CW    = $clog2(NUM_BUFS+1);
  localparam int DEPTH = NUM_BUFS * BUF_SIZE;
  localparam int MW    = $clog2(DEPTH);

  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic {R_IDLE, R_READ} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]         wr_addr, rd_addr;
  logic                  rd_rdy, wr_acc, rd_acc, commit, release_buf;
  logic [MW-1:0]         wr_ptr, rd_ptr;
  logic [BW-1:0]         wr_buf_nxt, rd_buf_nxt;

  assign wr_rdy      = bufs_full < CW'(NUM_BUFS);
  assign rd_rdy      = bufs_full != '0;
  assign wr_acc      = !wr_en_in && wr_rdy;
  assign rd_acc      = !rd_en_in && rd_rdy;
  assign commit      = wr_acc && (wr_addr == AW'(BUF_SIZE-1));
  assign release_buf = rd_acc && (rd_addr == AW'(BUF_SIZE-1));
  assign wr_ptr      = MW'(wr_buf_idx) * MW'(BUF_SIZE) + MW'(wr_addr);
  assign rd_ptr      = MW'(rd_buf_idx) * MW'(BUF_SIZE) + MW'(rd_addr);
  assign wr_buf_nxt  = (wr_buf_idx == BW'(NUM_BUFS-1)) ? '0 : wr_buf_idx + 1'b1;
  assign rd_buf_nxt  = (rd_buf_idx == BW'(NUM_BUFS-1)) ? '0 : rd_buf_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_acc && !commit) wr_state_nxt = W_FILL;
      W_FILL:  if (commit)            wr_state_nxt = W_IDLE;
      default:                        wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_acc && !release_buf) rd_state_nxt = R_READ;
      R_READ:  if (release_buf)            rd_state_nxt = R_IDLE;
      default:                             rd_state_nxt = R_IDLE;
    endcase
  end

  // Writes only ever target the uncommitted buffer, so no read/write address collision exists.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr       <= '0;
      rd_addr       <= '0;
      wr_buf_idx    <= '0;
      rd_buf_idx    <= '0;
      bufs_full     <= '0;
      data_out      <= '0;
      rd_data_valid <= 1'b0;
      frame_wr_done <= 1'b0;
      frame_rd_done <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      rd_data_valid <= rd_acc;
      frame_wr_done <= commit;
      frame_rd_done <= release_buf;
      if (!wr_en_in && !wr_rdy) overflow  <= 1'b1;
      if (!rd_en_in && !rd_rdy) underflow <= 1'b1;
      if (wr_acc) begin
        if (commit) begin
          wr_addr    <= '0;
          wr_buf_idx <= wr_buf_nxt;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        if (release_buf) begin
          rd_addr    <= '0;
          rd_buf_idx <= rd_buf_nxt;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
      case ({commit, release_buf})
        2'b10:   bufs_full <= bufs_full + 1'b1;
        2'b01:   bufs_full <= bufs_full - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_buf_multi.sv
// Directed bench for frame_buf_multi with DATA_WIDTH=8, BUF_SIZE=4, NUM_BUFS=2.
module tb_frame_buf_multi;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en_in = 1'b1;
  logic [7:0] data_in = '0;
  logic       wr_rdy;
  logic       rd_en_in = 1'b1;
  logic [7:0] data_out;
  logic       rd_data_valid, frame_wr_done, frame_rd_done;
  logic [1:0] bufs_full;
  logic       wr_buf_idx, rd_buf_idx;
  logic       overflow, underflow;

  int errors = 0;
  int checks = 0;

  frame_buf_multi #(.DATA_WIDTH(8), .BUF_SIZE(4), .NUM_BUFS(2)) dut (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .data_in(data_in), .wr_rdy(wr_rdy),
    .rd_en_in(rd_en_in), .data_out(data_out), .rd_data_valid(rd_data_valid),
    .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done), .bufs_full(bufs_full),
    .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en_in = 1'b1; rd_en_in = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".wr_rdy"}, wr_rdy, 1);
    chk({tag, ".bufs_full"}, bufs_full, 0);
    chk({tag, ".wr_idx"}, wr_buf_idx, 0);
    chk({tag, ".rd_idx"}, rd_buf_idx, 0);
    chk({tag, ".data_out"}, data_out, 0);
    chk({tag, ".valid"}, rd_data_valid, 0);
    chk({tag, ".pulses"}, {frame_wr_done, frame_rd_done}, 0);
    chk({tag, ".flags"}, {overflow, underflow}, 0);
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en_in = 1'b0; data_in = d;
    tick();
    wr_en_in = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    rd_en_in = 1'b0;
    tick();
    rd_en_in = 1'b1;
    chk({tag, ".valid"}, rd_data_valid, 1);
    chk({tag, ".data"}, data_out, exp);
  endtask

  task automatic both(input string tag, input logic [7:0] d, input logic [7:0] exp);
    wr_en_in = 1'b0; data_in = d; rd_en_in = 1'b0;
    tick();
    wr_en_in = 1'b1; rd_en_in = 1'b1;
    chk({tag, ".valid"}, rd_data_valid, 1);
    chk({tag, ".data"}, data_out, exp);
  endtask

  initial begin
    // basic frame round trip
    do_reset();
    chk_reset_state("rst");
    for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i));
    chk("s1.wr_done", frame_wr_done, 1);
    chk("s1.full", bufs_full, 1);
    chk("s1.wr_idx", wr_buf_idx, 1);
    tick();
    chk("s1.wr_done_pulse", frame_wr_done, 0);
    for (int i = 0; i < 4; i++) rd_chk("s1.rd", 8'h10 + 8'(i));
    chk("s1.rd_done", frame_rd_done, 1);
    chk("s1.full0", bufs_full, 0);
    chk("s1.rd_idx", rd_buf_idx, 1);
    tick();
    chk("s1.rd_done_pulse", frame_rd_done, 0);
    chk("s1.idle_valid", rd_data_valid, 0);
    chk("s1.hold", data_out, 8'h13);

    // fill both buffers, then overflow
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'h20 + 8'(i));
    chk("s2.full", bufs_full, 2);
    chk("s2.wr_rdy", wr_rdy, 0);
    wr(8'hFF);
    chk("s2.ovf", overflow, 1);
    chk("s2.wr_idx", wr_buf_idx, 0);
    chk("s2.full_kept", bufs_full, 2);
    chk("s2.wr_done_none", frame_wr_done, 0);
    for (int i = 0; i < 8; i++) rd_chk("s2.rd", 8'h20 + 8'(i));
    chk("s2.full0", bufs_full, 0);
    chk("s2.ovf_sticky", overflow, 1);

    // underflow on empty
    do_reset();
    rd_en_in = 1'b0;
    tick();
    rd_en_in = 1'b1;
    chk("s3.valid", rd_data_valid, 0);
    chk("s3.udf", underflow, 1);
    chk("s3.rd_idx", rd_buf_idx, 0);
    chk("s3.full", bufs_full, 0);
    tick();
    chk("s3.udf_sticky", underflow, 1);
    chk("s3.ovf", overflow, 0);

    // same-cycle commit and release
    do_reset();
    for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i));
    for (int i = 0; i < 3; i++) wr(8'h30 + 8'(i));
    for (int i = 0; i < 3; i++) rd_chk("s4.rd", 8'h40 + 8'(i));
    chk("s4.full_pre", bufs_full, 1);
    both("s4.both", 8'h33, 8'h43);
    chk("s4.pulses", {frame_wr_done, frame_rd_done}, 2'b11);
    chk("s4.full", bufs_full, 1);
    chk("s4.rd_idx", rd_buf_idx, 1);
    chk("s4.wr_idx", wr_buf_idx, 0);
    for (int i = 0; i < 4; i++) rd_chk("s4.rd1", 8'h30 + 8'(i));
    chk("s4.full0", bufs_full, 0);

    // reset mid-frame discards the partial frame
    do_reset();
    wr(8'hAA); wr(8'hBB);
    rd_en_in = 1'b0; tick(); rd_en_in = 1'b1;
    do_reset();
    chk_reset_state("s5.rst");
    for (int i = 0; i < 4; i++) wr(8'h50 + 8'(i));
    chk("s5.wr_done", frame_wr_done, 1);
    chk("s5.wr_idx", wr_buf_idx, 1);
    chk("s5.full", bufs_full, 1);
    for (int i = 0; i < 4; i++) rd_chk("s5.rd", 8'h50 + 8'(i));

    // three streamed frames with interleaved reads
    do_reset();
    for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i));
    for (int f = 1; f < 3; f++) begin
      for (int i = 0; i < 4; i++)
        both("s6.both", 8'h60 + 8'(4*f + i), 8'h60 + 8'(4*(f-1) + i));
      chk("s6.full", bufs_full, 1);
      chk("s6.wr_idx", wr_buf_idx, (f == 1) ? 1'b0 : 1'b1);
      chk("s6.rd_idx", rd_buf_idx, (f == 1) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 4; i++) rd_chk("s6.rd", 8'h68 + 8'(i));
    chk("s6.rd_idx_end", rd_buf_idx, 1);
    chk("s6.full0", bufs_full, 0);
    chk("s6.flags", {overflow, underflow}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
